// File: rtl/dmc_cache_array.sv
// Tag/data storage for the direct-mapped cache: word read/write with hit/flush/fetch pulses and whole-line fills.
// Optional hit/miss statistics counters are enabled by defining DMC_STATS_EN.
module dmc_cache_array #(
    parameter int BLOCK_SIZE             = 32,
    parameter int NUM_OF_BLOCKS_PER_LINE = 4,
    parameter int NUM_OF_CACHE_LINES     = 4,
    parameter int ADDRESS_SIZE           = 32
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic                                         read_i,
    input  logic                                         write_i,
    input  logic                                         read_line_i,
    input  logic                                         write_line_i,
    input  logic [ADDRESS_SIZE-1:0]                      address_i,
    input  logic [BLOCK_SIZE-1:0]                        data_i,
    input  logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] line_i,
    output logic [BLOCK_SIZE-1:0]                        data_o,
    output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] line_o,
    output logic [ADDRESS_SIZE-1:0]                      address_o,
    output logic                                         hit_o,
    output logic                                         read_flush_o,
    output logic                                         read_fetch_o,
    output logic                                         write_flush_o,
    output logic                                         write_fetch_o
`ifdef DMC_STATS_EN
    ,
    output logic [31:0]                                  hit_count_o,
    output logic [31:0]                                  miss_count_o
`endif
);

    localparam int OFF = $clog2(NUM_OF_BLOCKS_PER_LINE);
    localparam int IDX = $clog2(NUM_OF_CACHE_LINES);
    localparam int TAG = ADDRESS_SIZE - OFF - IDX;
    localparam int LW  = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;

    logic [NUM_OF_CACHE_LINES-1:0] valid_q;
    logic [NUM_OF_CACHE_LINES-1:0] dirty_q;
    logic [TAG-1:0]                tag_q  [NUM_OF_CACHE_LINES];
    logic [LW-1:0]                 line_q [NUM_OF_CACHE_LINES];

    logic [OFF-1:0] off;
    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic           hit;
    logic           dirty_victim;
    logic           do_fill;
    logic           do_write;
    logic           do_read;
    logic           unused_read_line;

    // line_o is always valid, so the line-read strobe carries no information here
    assign unused_read_line = read_line_i;

    assign off          = address_i[0 +: OFF];
    assign idx          = address_i[OFF +: IDX];
    assign tag          = address_i[OFF+IDX +: TAG];
    assign hit          = valid_q[idx] && (tag_q[idx] == tag);
    assign dirty_victim = valid_q[idx] && dirty_q[idx];

    assign do_fill  = write_line_i;
    assign do_write = !write_line_i && write_i;
    assign do_read  = !write_line_i && !write_i && read_i;

    assign line_o    = line_q[idx];
    assign address_o = {tag_q[idx], idx, {OFF{1'b0}}};

    // Tag and data storage carry no reset so they can map onto plain RAM
    always_ff @(posedge clk_i) begin
        if (do_fill) begin
            line_q[idx] <= line_i;
            tag_q[idx]  <= tag;
        end else if (do_write && hit) begin
            line_q[idx][off*BLOCK_SIZE +: BLOCK_SIZE] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (do_fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (do_write && hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Each response pulse lives for exactly one cycle after the sampling edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_o         <= 1'b0;
            read_flush_o  <= 1'b0;
            read_fetch_o  <= 1'b0;
            write_flush_o <= 1'b0;
            write_fetch_o <= 1'b0;
            data_o        <= '0;
        end else begin
            hit_o         <= (do_read || do_write) && hit;
            read_flush_o  <= do_read && !hit && dirty_victim;
            read_fetch_o  <= do_read && !hit && !dirty_victim;
            write_flush_o <= do_write && !hit && dirty_victim;
            write_fetch_o <= do_write && !hit && !dirty_victim;
            if (do_read && hit) begin
                data_o <= line_q[idx][off*BLOCK_SIZE +: BLOCK_SIZE];
            end
        end
    end

`ifdef DMC_STATS_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (do_read || do_write) begin
            if (hit && hit_count_o != 32'hFFFF_FFFF) begin
                hit_count_o <= hit_count_o + 32'd1;
            end
            if (!hit && miss_count_o != 32'hFFFF_FFFF) begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmc_cache_array.sv
// Self-checking bench for dmc_cache_array: directed vector table, reset corner case, and randomized
// traffic against an address-arithmetic reference model.
module tb_dmc_cache_array;

    localparam int BS = 32;
    localparam int NB = 4;
    localparam int NL = 4;
    localparam int AS = 32;
    localparam int LW = NB * BS;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_HIT  = 5'b10000;
    localparam logic [4:0] P_RFL  = 5'b01000;
    localparam logic [4:0] P_RFE  = 5'b00100;
    localparam logic [4:0] P_WFL  = 5'b00010;
    localparam logic [4:0] P_WFE  = 5'b00001;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          read_i;
    logic          write_i;
    logic          read_line_i;
    logic          write_line_i;
    logic [AS-1:0] address_i;
    logic [BS-1:0] data_i;
    logic [LW-1:0] line_i;
    logic [BS-1:0] data_o;
    logic [LW-1:0] line_o;
    logic [AS-1:0] address_o;
    logic          hit_o;
    logic          read_flush_o;
    logic          read_fetch_o;
    logic          write_flush_o;
    logic          write_fetch_o;
`ifdef DMC_STATS_EN
    logic [31:0]   hit_count_o;
    logic [31:0]   miss_count_o;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    dmc_cache_array #(
        .BLOCK_SIZE(BS),
        .NUM_OF_BLOCKS_PER_LINE(NB),
        .NUM_OF_CACHE_LINES(NL),
        .ADDRESS_SIZE(AS)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .read_i(read_i),
        .write_i(write_i),
        .read_line_i(read_line_i),
        .write_line_i(write_line_i),
        .address_i(address_i),
        .data_i(data_i),
        .line_i(line_i),
        .data_o(data_o),
        .line_o(line_o),
        .address_o(address_o),
        .hit_o(hit_o),
        .read_flush_o(read_flush_o),
        .read_fetch_o(read_fetch_o),
        .write_flush_o(write_flush_o),
        .write_fetch_o(write_fetch_o)
`ifdef DMC_STATS_EN
        ,
        .hit_count_o(hit_count_o),
        .miss_count_o(miss_count_o)
`endif
    );

    typedef struct {
        logic          rd;
        logic          wr;
        logic          wl;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [LW-1:0] line;
        logic [4:0]    exp_pulse;
        logic [31:0]   exp_data;
        logic          chk_addr;
        logic [31:0]   exp_addr;
        logic          chk_line;
        logic [LW-1:0] exp_line;
    } vec_t;

    vec_t vecs[12];

    // Reference model: state per line, indexed by plain address arithmetic
    bit          m_valid [NL];
    bit          m_dirty [NL];
    logic [31:0] m_tag   [NL];
    logic [31:0] m_data  [NL][NB];
    logic [31:0] m_dout;

    // Drives one request for a single clock edge and leaves the bench #1 after that edge
    task automatic applyStimulus(input logic rd, input logic wr, input logic wl, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [LW-1:0] line);
        read_i       = rd;
        write_i      = wr;
        write_line_i = wl;
        read_line_i  = 1'b0;
        address_i    = addr;
        data_i       = data;
        line_i       = line;
        @(posedge clk_i);
        #1;
        read_i       = 1'b0;
        write_i      = 1'b0;
        write_line_i = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] exp_pulse, input logic [31:0] exp_data);
        logic [4:0] act;
        act = {hit_o, read_flush_o, read_fetch_o, write_flush_o, write_fetch_o};
        tests_run++;
        if (act !== exp_pulse || data_o !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL %s: pulses(hit,rfl,rfe,wfl,wfe)=%b data_o=%h, required pulses=%b data_o=%h",
                     name, act, data_o, exp_pulse, exp_data);
        end
    endtask

    task automatic checkValue(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst_n_i      = 1'b0;
        read_i       = 1'b0;
        write_i      = 1'b0;
        write_line_i = 1'b0;
        read_line_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_dout = '0;
    endtask

    initial begin
        int          idx;
        int          off;
        logic [31:0] tag;
        logic [31:0] addr;
        logic [31:0] data;
        logic [LW-1:0] line;
        logic [LW-1:0] exp_line;
        logic        rd;
        logic        wr;
        logic        wl;
        logic [4:0]  exp_p;
        bit          mhit;

        address_i = '0;
        data_i    = '0;
        line_i    = '0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, '0, P_RFE, 32'h0, 1'b0, 32'h0, 1'b0, '0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h10, 32'h0,
                     {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000},
                     P_NONE, 32'h0, 1'b1, 32'h10, 1'b0, '0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h12, 32'h0, '0, P_HIT, 32'h22222222, 1'b1, 32'h10, 1'b0, '0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h11, 32'hDEADBEEF, '0, P_HIT, 32'h22222222, 1'b1, 32'h10, 1'b0, '0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h50, 32'h0, '0, P_RFL, 32'h22222222, 1'b1, 32'h10, 1'b1,
                     {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h00000000}};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h20, 32'h0,
                     {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0},
                     P_NONE, 32'h22222222, 1'b1, 32'h20, 1'b0, '0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h60, 32'h12345678, '0, P_WFE, 32'h22222222, 1'b1, 32'h20, 1'b0, '0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h21, 32'h0, '0, P_HIT, 32'hA1A1A1A1, 1'b1, 32'h20, 1'b1,
                     {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h30, 32'h55555555,
                     {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0},
                     P_NONE, 32'hA1A1A1A1, 1'b1, 32'h30, 1'b1,
                     {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0}};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h31, 32'hCAFEF00D, '0, P_HIT, 32'hA1A1A1A1, 1'b1, 32'h30, 1'b0, '0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h31, 32'h0, '0, P_HIT, 32'hCAFEF00D, 1'b1, 32'h30, 1'b0, '0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h35, 32'h0, '0, P_RFE, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, '0};

        doReset();
        checkOutput("reset_state", P_NONE, 32'h0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].wl, vecs[i].addr, vecs[i].data, vecs[i].line);
            checkOutput($sformatf("vec%0d_resp", i), vecs[i].exp_pulse, vecs[i].exp_data);
            if (vecs[i].chk_addr) begin
                checkValue($sformatf("vec%0d_address_o", i), LW'(address_o), LW'(vecs[i].exp_addr));
            end
            if (vecs[i].chk_line) begin
                checkValue($sformatf("vec%0d_line_o", i), line_o, vecs[i].exp_line);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, vecs[i].addr, 32'h0, '0);
            checkOutput($sformatf("vec%0d_idle", i), P_NONE, vecs[i].exp_data);
        end

        // Reset lands while a read of a dirty resident line is pending
        address_i = 32'h31;
        read_i    = 1'b1;
        #2 rst_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("reset_mid_read", P_NONE, 32'h0);
        read_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("after_reset_idle", P_NONE, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h11, 32'h0, '0);
        checkOutput("after_reset_read", P_RFE, 32'h0);

        doReset();
        for (int n = 0; n < 400; n++) begin
            idx = $urandom_range(0, NL - 1);
            off = $urandom_range(0, NB - 1);
            tag = ($urandom_range(0, 15) == 0) ? ($urandom() >> 4) : 32'($urandom_range(0, 2));
            addr = (tag << 4) | 32'(idx << 2) | 32'(off);
            data = $urandom();
            line = {$urandom(), $urandom(), $urandom(), $urandom()};
            wl = ($urandom_range(0, 99) < 15);
            wr = ($urandom_range(0, 99) < 40);
            rd = ($urandom_range(0, 99) < 50);

            mhit  = m_valid[idx] && (m_tag[idx] == tag);
            exp_p = P_NONE;
            if (wl) begin
                for (int k = 0; k < NB; k++) m_data[idx][k] = line[k*BS +: BS];
                m_tag[idx]   = tag;
                m_valid[idx] = 1'b1;
                m_dirty[idx] = 1'b0;
            end else if (wr) begin
                if (mhit) begin
                    m_data[idx][off] = data;
                    m_dirty[idx]     = 1'b1;
                    exp_p = P_HIT;
                end else begin
                    exp_p = (m_valid[idx] && m_dirty[idx]) ? P_WFL : P_WFE;
                end
            end else if (rd) begin
                if (mhit) begin
                    m_dout = m_data[idx][off];
                    exp_p  = P_HIT;
                end else begin
                    exp_p = (m_valid[idx] && m_dirty[idx]) ? P_RFL : P_RFE;
                end
            end

            applyStimulus(rd, wr, wl, addr, data, line);
            checkOutput($sformatf("rand%0d_resp", n), exp_p, m_dout);
            if (m_valid[idx]) begin
                for (int k = 0; k < NB; k++) exp_line[k*BS +: BS] = m_data[idx][k];
                checkValue($sformatf("rand%0d_line_o", n), line_o, exp_line);
                checkValue($sformatf("rand%0d_address_o", n), LW'(address_o),
                           LW'((m_tag[idx] << 4) | 32'(idx << 2)));
            end
        end

`ifdef DMC_STATS_EN
        doReset();
        checkValue("stats_reset_hits", LW'(hit_count_o), LW'(0));
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, {32'h3, 32'h2, 32'h1, 32'h0});
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h11, 32'h0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h12, 32'h77, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h50, 32'h0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h04, 32'h0, '0);
        checkValue("stats_hits", LW'(hit_count_o), LW'(3));
        checkValue("stats_misses", LW'(miss_count_o), LW'(2));
        doReset();
        checkValue("stats_cleared_hits", LW'(hit_count_o), LW'(0));
        checkValue("stats_cleared_misses", LW'(miss_count_o), LW'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
